// File: rtl/ofb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ofb_pkg : shared widths and FSM encoding for the OFB sequencer
// Rev 1.0
// ------------------------------------------------------------------
package ofb_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 128;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_IN = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_OUT     = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_WAIT_IN = ST_WAIT_IN,
    S_LOAD    = ST_LOAD,
    S_RUN     = ST_RUN,
    S_OUT     = ST_OUT,
    S_ERR     = ST_ERR
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ofb_wdog.sv
`default_nettype none
// ------------------------------------------------------------------
// ofb_wdog : loadable down-counter flagging a core that never answers
// Rev 1.0
// ------------------------------------------------------------------
module ofb_wdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int                 c_cnt_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_timeout;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  // Expiry is the cycle whose decrement would reach zero.
  assign o_expired = i_en && (r_cnt == c_one);

endmodule
`default_nettype wire

// File: rtl/ofb_msg_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// ofb_msg_sequencer : streams a multi-block message through one OFB core
// Rev 1.0
// ------------------------------------------------------------------
module ofb_msg_sequencer
  import ofb_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_start,
  input  logic             msg_abort,
  input  logic [KEY_W-1:0] msg_key,
  input  logic [BLK_W-1:0] msg_iv,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             core_ld,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_iv,
  output logic [BLK_W-1:0] core_data_in,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_data_out,
  output logic             busy,
  output logic             msg_done,
  output logic             err
);

  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [KEY_W-1:0] r_key;
  logic [BLK_W-1:0] r_iv;
  logic [BLK_W-1:0] r_data;
  logic [BLK_W-1:0] r_out;
  logic [LEN_W-1:0] r_rem;
  logic             r_err;
  logic             r_msg_done;

  logic w_start_ok;
  logic w_in_acc;
  logic w_core_acc;
  logic w_out_acc;
  logic w_last;
  logic w_wd_en;
  logic w_wd_expired;

  assign w_last     = (r_rem == c_len_one);
  assign w_start_ok = (r_state == S_IDLE) && msg_start && (msg_len != '0) && !msg_abort;
  assign w_in_acc   = (r_state == S_WAIT_IN) && in_valid && !msg_abort;
  assign w_core_acc = (r_state == S_RUN) && core_done && !msg_abort;
  assign w_out_acc  = (r_state == S_OUT) && out_ready && !msg_abort;
  // The count starts on the core_ld cycle so err lands TIMEOUT cycles after core_ld.
  assign w_wd_en    = (r_state == S_LOAD) || (r_state == S_RUN);

  ofb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_in_acc),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (msg_start && (msg_len != '0)) w_next = S_WAIT_IN;
      S_WAIT_IN: if (in_valid) w_next = S_LOAD;
      S_LOAD:    w_next = S_RUN;
      S_RUN: begin
        if (core_done) begin
          w_next = S_OUT;
        end else if (w_wd_expired) begin
          w_next = S_ERR;
        end
      end
      S_OUT:     if (out_ready) w_next = w_last ? S_IDLE : S_WAIT_IN;
      S_ERR:     w_next = S_ERR;
      default:   w_next = S_IDLE;
    endcase
    if (msg_abort) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key      <= '0;
      r_iv       <= '0;
      r_data     <= '0;
      r_out      <= '0;
      r_rem      <= '0;
      r_err      <= 1'b0;
      r_msg_done <= 1'b0;
    end else begin
      r_msg_done <= w_out_acc && w_last;
      if (msg_abort) begin
        r_err <= 1'b0;
      end else if ((r_state == S_RUN) && !core_done && w_wd_expired) begin
        r_err <= 1'b1;
      end
      if (w_start_ok) begin
        r_key <= msg_key;
        r_iv  <= msg_iv;
        r_rem <= msg_len;
      end
      if (w_in_acc) begin
        r_data <= in_data;
      end
      // OFB chaining: recover the raw keystream block as the next IV.
      if (w_core_acc) begin
        r_out <= core_data_out;
        r_iv  <= core_data_out ^ r_data;
      end
      if (w_out_acc) begin
        r_rem <= r_rem - c_len_one;
      end
    end
  end

  assign in_ready     = (r_state == S_WAIT_IN);
  assign out_valid    = (r_state == S_OUT);
  assign out_data     = r_out;
  assign out_last     = (r_state == S_OUT) && w_last;
  assign core_ld      = (r_state == S_LOAD);
  assign core_key     = r_key;
  assign core_iv      = r_iv;
  assign core_data_in = r_data;
  assign busy         = (r_state != S_IDLE);
  assign msg_done     = r_msg_done;
  assign err          = r_err;

endmodule
`default_nettype wire
